// File: rtl/bls12_381_fe12_collect.sv
`default_nettype none
// ============================================================================
//  Module   : bls12_381_fe12_collect
//  Purpose  : Collects the serial Fp12 result stream of the BLS12-381 pairing
//             wrapper (one Fp coefficient per beat, sop/eop framed) into a
//             parallel fe12 word. Flags a result equal to Fp12 one and any
//             framing error, then holds it in a single-entry output buffer
//             behind a valid/ready handshake.
//  Ports    : i_clk, i_rst (async, active-low)
//             i_fe_dat/i_fe_val/i_fe_sop/i_fe_eop/i_fe_ctl -> o_fe_rdy  beat input
//             o_fe12/o_ctl/o_is_one/o_err/o_val <- i_rdy               result output
//  Revision : 1.0  initial release
// ============================================================================
module bls12_381_fe12_collect #(
  parameter int FE_BITS  = 381,
  parameter int NUM_COEF = 12,
  parameter int CTL_BITS = 128
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [FE_BITS-1:0]           i_fe_dat,
  input  logic                         i_fe_val,
  input  logic                         i_fe_sop,
  input  logic                         i_fe_eop,
  input  logic [CTL_BITS-1:0]          i_fe_ctl,
  output logic                         o_fe_rdy,
  output logic [NUM_COEF*FE_BITS-1:0]  o_fe12,
  output logic [CTL_BITS-1:0]          o_ctl,
  output logic                         o_is_one,
  output logic                         o_err,
  output logic                         o_val,
  input  logic                         i_rdy
);

  localparam int                  CNT_BITS = $clog2(NUM_COEF);
  localparam logic [CNT_BITS-1:0] C_LAST   = CNT_BITS'(NUM_COEF - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  state_t                        r_state;
  logic [CNT_BITS-1:0]           r_cnt;
  logic [NUM_COEF*FE_BITS-1:0]   r_fe12;
  logic [CTL_BITS-1:0]           r_ctl;
  logic                          r_one;
  logic                          r_err;
  logic                          r_val;
  logic                          r_rdy;
  logic                          r_long;

  logic w_beat;
  logic w_first;
  logic w_last;
  logic w_err_beat;
  logic w_one_beat;

  assign w_beat  = i_fe_val & r_rdy;
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == C_LAST);

  // Tracker values including the current beat. Beat 0 restarts both
  // trackers; later beats accumulate into them.
  assign w_err_beat = w_first ? ~i_fe_sop : (r_err | i_fe_sop);
  assign w_one_beat = w_first ? (i_fe_dat == FE_BITS'(1))
                              : (r_one & (i_fe_dat == '0));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_COLLECT;
      r_cnt   <= '0;
      r_fe12  <= '0;
      r_ctl   <= '0;
      r_one   <= 1'b0;
      r_err   <= 1'b0;
      r_val   <= 1'b0;
      r_rdy   <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          r_rdy <= 1'b1;
          if (w_beat) begin
            // Beat 0 wipes every slot so a short frame leaves zeros behind.
            if (w_first) begin
              r_fe12 <= (NUM_COEF*FE_BITS)'(i_fe_dat);
              r_ctl  <= i_fe_ctl;
            end else begin
              for (int n = 0; n < NUM_COEF; n++) begin
                if (r_cnt == CNT_BITS'(n)) begin
                  r_fe12[n*FE_BITS +: FE_BITS] <= i_fe_dat;
                end
              end
            end

            if (i_fe_eop) begin
              r_state <= ST_HOLD;
              r_rdy   <= 1'b0;
              r_val   <= 1'b1;
              r_long  <= 1'b0;
              if (w_last) begin
                r_err <= w_err_beat;
                r_one <= w_one_beat;
              end else begin
                r_err <= 1'b1;
                r_one <= 1'b0;
              end
            end else if (w_last) begin
              // Long frame: present what we have and discard the tail
              // afterwards, so the buffered result is never overwritten.
              r_state <= ST_HOLD;
              r_rdy   <= 1'b0;
              r_val   <= 1'b1;
              r_long  <= 1'b1;
              r_err   <= 1'b1;
              r_one   <= w_one_beat;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              r_err <= w_err_beat;
              r_one <= w_one_beat;
            end
          end
        end

        ST_HOLD: begin
          if (i_rdy) begin
            r_val   <= 1'b0;
            r_rdy   <= 1'b1;
            r_cnt   <= '0;
            r_long  <= 1'b0;
            r_state <= r_long ? ST_DRAIN : ST_COLLECT;
          end
        end

        ST_DRAIN: begin
          r_rdy <= 1'b1;
          if (w_beat && i_fe_eop) begin
            r_state <= ST_COLLECT;
          end
        end

        default: begin
          r_state <= ST_COLLECT;
          r_cnt   <= '0;
          r_val   <= 1'b0;
          r_rdy   <= 1'b0;
          r_long  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fe_rdy = r_rdy;
  assign o_fe12   = r_fe12;
  assign o_ctl    = r_ctl;
  assign o_is_one = r_one;
  assign o_err    = r_err;
  assign o_val    = r_val;

endmodule
`default_nettype wire

// File: tb/tb_bls12_381_fe12_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bls12_381_fe12_collect
//  Purpose  : Directed self-checking bench for bls12_381_fe12_collect.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bls12_381_fe12_collect;

  localparam int FE_BITS  = 381;
  localparam int NUM_COEF = 12;
  localparam int CTL_BITS = 128;

  logic                         i_clk = 1'b0;
  logic                         i_rst = 1'b0;
  logic [FE_BITS-1:0]           i_fe_dat = '0;
  logic                         i_fe_val = 1'b0;
  logic                         i_fe_sop = 1'b0;
  logic                         i_fe_eop = 1'b0;
  logic [CTL_BITS-1:0]          i_fe_ctl = '0;
  logic                         o_fe_rdy;
  logic [NUM_COEF*FE_BITS-1:0]  o_fe12;
  logic [CTL_BITS-1:0]          o_ctl;
  logic                         o_is_one;
  logic                         o_err;
  logic                         o_val;
  logic                         i_rdy = 1'b0;

  always #5 i_clk = ~i_clk;

  bls12_381_fe12_collect #(
    .FE_BITS  (FE_BITS),
    .NUM_COEF (NUM_COEF),
    .CTL_BITS (CTL_BITS)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_fe_dat (i_fe_dat),
    .i_fe_val (i_fe_val),
    .i_fe_sop (i_fe_sop),
    .i_fe_eop (i_fe_eop),
    .i_fe_ctl (i_fe_ctl),
    .o_fe_rdy (o_fe_rdy),
    .o_fe12   (o_fe12),
    .o_ctl    (o_ctl),
    .o_is_one (o_is_one),
    .o_err    (o_err),
    .o_val    (o_val),
    .i_rdy    (i_rdy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [FE_BITS-1:0] beat_dat [0:15];
  logic [FE_BITS-1:0] exp_slot [0:NUM_COEF-1];

  task automatic chk(input string tag, input logic [FE_BITS-1:0] obs,
                     input logic [FE_BITS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until the DUT takes it (bounded wait).
  task automatic send_beat(input logic [FE_BITS-1:0] dat, input logic sop,
                           input logic eop);
    int cyc;
    cyc = 0;
    i_fe_dat = dat;
    i_fe_sop = sop;
    i_fe_eop = eop;
    i_fe_val = 1'b1;
    while (o_fe_rdy !== 1'b1 && cyc < 50) begin
      @(posedge i_clk); #1;
      cyc++;
    end
    chk("beat_rdy", {380'd0, o_fe_rdy}, 381'd1);
    @(posedge i_clk); #1;
  endtask

  task automatic send_frame(input int n, input bit eop_last,
                            input bit expect_hold, input string frm);
    for (int b = 0; b < n; b++) begin
      send_beat(beat_dat[b], (b == 0), (eop_last && (b == n - 1)));
    end
    i_fe_val = 1'b0;
    i_fe_sop = 1'b0;
    i_fe_eop = 1'b0;
    if (expect_hold) chk({frm, ".val_lat"}, {380'd0, o_val}, 381'd1);
  endtask

  task automatic check_result(input string frm, input logic exp_one,
                              input logic exp_err, input logic [CTL_BITS-1:0] exp_ctl);
    chk({frm, ".val"}, {380'd0, o_val}, 381'd1);
    chk({frm, ".fe_rdy"}, {380'd0, o_fe_rdy}, 381'd0);
    chk({frm, ".is_one"}, {380'd0, o_is_one}, {380'd0, exp_one});
    chk({frm, ".err"}, {380'd0, o_err}, {380'd0, exp_err});
    chk({frm, ".ctl"}, FE_BITS'(o_ctl), FE_BITS'(exp_ctl));
    for (int n = 0; n < NUM_COEF; n++) begin
      chk($sformatf("%s.slot%0d", frm, n), o_fe12[n*FE_BITS +: FE_BITS], exp_slot[n]);
    end
  endtask

  task automatic take_result(input string frm, input logic exp_one,
                             input logic exp_err, input logic [CTL_BITS-1:0] exp_ctl);
    check_result(frm, exp_one, exp_err, exp_ctl);
    i_rdy = 1'b1;
    @(posedge i_clk); #1;
    i_rdy = 1'b0;
    chk({frm, ".val_drop"}, {380'd0, o_val}, 381'd0);
    chk({frm, ".rdy_back"}, {380'd0, o_fe_rdy}, 381'd1);
  endtask

  task automatic load_one_frame();
    for (int b = 0; b < 16; b++) beat_dat[b] = '0;
    beat_dat[0] = 381'd1;
    for (int n = 0; n < NUM_COEF; n++) exp_slot[n] = '0;
    exp_slot[0] = 381'd1;
  endtask

  task automatic load_ramp(input logic [FE_BITS-1:0] base);
    for (int b = 0; b < 16; b++) beat_dat[b] = base + FE_BITS'(b);
    for (int n = 0; n < NUM_COEF; n++) exp_slot[n] = base + FE_BITS'(n);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst.val", {380'd0, o_val}, 381'd0);
    chk("rst.fe_rdy", {380'd0, o_fe_rdy}, 381'd0);
    chk("rst.is_one", {380'd0, o_is_one}, 381'd0);
    chk("rst.err", {380'd0, o_err}, 381'd0);
    chk("rst.ctl", FE_BITS'(o_ctl), 381'd0);
    chk("rst.slot0", o_fe12[0 +: FE_BITS], 381'd0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("rst.rdy_after", {380'd0, o_fe_rdy}, 381'd1);

    // Fp12 one
    load_one_frame();
    i_fe_ctl = 128'h11;
    send_frame(12, 1'b1, 1'b1, "one");
    take_result("one", 1'b1, 1'b0, 128'h11);

    // Ramp values with backpressure for 20 cycles
    load_ramp(381'h100);
    i_fe_ctl = 128'hA5;
    send_frame(12, 1'b1, 1'b1, "ramp");
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      chk("bp.fe_rdy", {380'd0, o_fe_rdy}, 381'd0);
      chk("bp.val", {380'd0, o_val}, 381'd1);
      chk("bp.slot0", o_fe12[0 +: FE_BITS], 381'h100);
      chk("bp.slot11", o_fe12[11*FE_BITS +: FE_BITS], 381'h10b);
    end
    take_result("ramp", 1'b0, 1'b0, 128'hA5);

    // Short frame: eop on beat 4; slots 5..11 must be cleared
    load_one_frame();
    i_fe_ctl = 128'h22;
    send_frame(5, 1'b1, 1'b1, "short");
    take_result("short", 1'b0, 1'b1, 128'h22);

    load_ramp(381'h300);
    i_fe_ctl = 128'h33;
    send_frame(12, 1'b1, 1'b1, "post_short");
    take_result("post_short", 1'b0, 1'b0, 128'h33);

    // Long frame: 14 beats, eop on beat 13
    load_ramp(381'h200);
    i_fe_ctl = 128'h44;
    send_frame(12, 1'b0, 1'b1, "long");
    take_result("long", 1'b0, 1'b1, 128'h44);
    send_beat(381'hdead, 1'b0, 1'b0);
    send_beat(381'hbeef, 1'b0, 1'b1);
    i_fe_val = 1'b0;
    i_fe_eop = 1'b0;
    chk("drain.noval", {380'd0, o_val}, 381'd0);

    load_one_frame();
    i_fe_ctl = 128'h55;
    send_frame(12, 1'b1, 1'b1, "post_long");
    take_result("post_long", 1'b1, 1'b0, 128'h55);

    // Reset after beat 6
    load_ramp(381'h400);
    i_fe_ctl = 128'h77;
    send_frame(7, 1'b0, 1'b0, "mid");
    #2;
    i_rst = 1'b0;
    #1;
    chk("mrst.val", {380'd0, o_val}, 381'd0);
    chk("mrst.fe_rdy", {380'd0, o_fe_rdy}, 381'd0);
    chk("mrst.slot0", o_fe12[0 +: FE_BITS], 381'd0);
    chk("mrst.slot6", o_fe12[6*FE_BITS +: FE_BITS], 381'd0);
    chk("mrst.ctl", FE_BITS'(o_ctl), 381'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("mrst.rdy_after", {380'd0, o_fe_rdy}, 381'd1);

    load_ramp(381'h500);
    i_fe_ctl = 128'h66;
    send_frame(12, 1'b1, 1'b1, "post_rst");
    take_result("post_rst", 1'b0, 1'b0, 128'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
